// File: rtl/axis_beam_combiner.sv
// axis_beam_combiner
// Sums NUM_CH complex AXI-Stream channels lane by lane into one complex output
// stream. The per-channel enable mask is only allowed to change on packet
// boundaries. Each sum is rounded, right-shifted and then saturated or wrapped.
// Two register stages: stage 1 holds the wide sums, stage 2 holds the scaled
// output. Throughput is one beat per cycle, with full backpressure.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   s_axis_*             NUM_CH input channels (valid/ready/last per channel,
//                        real/imag data packed channel-major, lane-minor)
//   ch_mask              requested channel enable, applied at packet boundaries
//   m_axis_*             combined output stream (tkeep all ones while valid)
//   tlast_err            sticky flag: enabled channels disagreed on tlast
//   beat_count           output beats transferred since reset (wraps)
module axis_beam_combiner #(
  parameter int NUM_CH       = 4,
  parameter int SAMPLES      = 8,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SHIFT        = 2,
  parameter int SATURATE     = 1
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_CH-1:0]                      s_axis_tvalid,
  output logic [NUM_CH-1:0]                      s_axis_tready,
  input  logic [NUM_CH*SAMPLES*SAMPLE_WIDTH-1:0] s_axis_real_tdata,
  input  logic [NUM_CH*SAMPLES*SAMPLE_WIDTH-1:0] s_axis_imag_tdata,
  input  logic [NUM_CH-1:0]                      s_axis_tlast,
  input  logic [NUM_CH-1:0]                      ch_mask,
  output logic [SAMPLES*SAMPLE_WIDTH-1:0]        m_axis_real_tdata,
  output logic [SAMPLES*SAMPLE_WIDTH-1:0]        m_axis_imag_tdata,
  output logic [SAMPLES*SAMPLE_WIDTH/8-1:0]      m_axis_tkeep,
  output logic                                   m_axis_tlast,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic                                   tlast_err,
  output logic [31:0]                            beat_count
);

  localparam int DW  = SAMPLES * SAMPLE_WIDTH;
  localparam int KW  = DW / 8;
  localparam int SW  = SAMPLE_WIDTH + $clog2(NUM_CH) + 1;  // adder width, cannot overflow
  localparam int RW  = SW + 1;                              // headroom for the rounding add
  localparam int RND = (1 << SHIFT) >> 1;                   // 2^(SHIFT-1), or 0 when SHIFT=0
  localparam logic signed [RW-1:0] RND_V   = RW'(RND);
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  logic [NUM_CH-1:0]        active_mask;
  logic                     mask_init;     // high until the first post-reset edge loads the mask
  logic                     pipe_en, join_ok, accept;
  logic                     beat_last, last_mismatch;
  logic signed [SW-1:0]     sum_re [SAMPLES];
  logic signed [SW-1:0]     sum_im [SAMPLES];
  logic                     s1_valid, s1_last;
  logic signed [SW-1:0]     s1_re [SAMPLES];
  logic signed [SW-1:0]     s1_im [SAMPLES];

  function automatic logic signed [SW-1:0] sext(input logic [SAMPLE_WIDTH-1:0] x);
    return {{(SW-SAMPLE_WIDTH){x[SAMPLE_WIDTH-1]}}, x};
  endfunction

  // Round half toward +inf, arithmetic shift, then clamp or keep the LSBs.
  function automatic logic [SAMPLE_WIDTH-1:0] scale(input logic signed [SW-1:0] v);
    logic signed [RW-1:0] r;
    logic [SAMPLE_WIDTH-1:0] res;
    r = $signed({v[SW-1], v}) + RND_V;
    r = r >>> SHIFT;
    if (SATURATE != 0) begin
      if (r > SAT_MAX)      res = SAT_MAX[SAMPLE_WIDTH-1:0];
      else if (r < SAT_MIN) res = SAT_MIN[SAMPLE_WIDTH-1:0];
      else                  res = r[SAMPLE_WIDTH-1:0];
    end else begin
      res = r[SAMPLE_WIDTH-1:0];
    end
    return res;
  endfunction

  // Join and handshake. Disabled channels are always ready, so they drain.
  // Ready is held low during the mask-load cycle, so that no beat is drained
  // before the real mask is known.
  always_comb begin : join_logic
    pipe_en       = !m_axis_tvalid || m_axis_tready;
    join_ok       = ((s_axis_tvalid & active_mask) == active_mask);
    accept        = pipe_en && join_ok && (active_mask != '0) && !mask_init && !reset;
    s_axis_tready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset || mask_init)  s_axis_tready[c] = 1'b0;
      else if (active_mask[c]) s_axis_tready[c] = accept;
      else                     s_axis_tready[c] = 1'b1;
    end
  end

  // Beat tlast is taken from the lowest enabled channel; the mismatch flags disagreement.
  always_comb begin : tlast_join
    logic found, any_last, all_last;
    found     = 1'b0;
    any_last  = 1'b0;
    all_last  = 1'b1;
    beat_last = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      beat_last = (!found && active_mask[c]) ? s_axis_tlast[c] : beat_last;
      found     = found || active_mask[c];
      any_last  = any_last || (active_mask[c] && s_axis_tlast[c]);
      all_last  = all_last && (!active_mask[c] || s_axis_tlast[c]);
    end
    last_mismatch = any_last && !all_last;
  end

  // Per-lane sum of the sign-extended samples of enabled channels.
  always_comb begin : adder
    logic signed [SW-1:0] acc_re, acc_im;
    for (int i = 0; i < SAMPLES; i++) begin
      acc_re = {SW{1'b0}};
      acc_im = {SW{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        acc_re = acc_re + (active_mask[c] ?
                 sext(s_axis_real_tdata[(c*SAMPLES+i)*SAMPLE_WIDTH +: SAMPLE_WIDTH]) : {SW{1'b0}});
        acc_im = acc_im + (active_mask[c] ?
                 sext(s_axis_imag_tdata[(c*SAMPLES+i)*SAMPLE_WIDTH +: SAMPLE_WIDTH]) : {SW{1'b0}});
      end
      sum_re[i] = acc_re;
      sum_im[i] = acc_im;
    end
  end

  // Control state: packet-boundary mask reload, sticky tlast error, beat counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_mask <= '0;
      mask_init   <= 1'b1;
      tlast_err   <= 1'b0;
      beat_count  <= 32'd0;
    end else begin
      if (mask_init) begin
        active_mask <= ch_mask;
        mask_init   <= 1'b0;
      end else if (accept && beat_last) begin
        active_mask <= ch_mask;   // the new mask applies from the next beat
      end
      if (accept && last_mismatch) tlast_err <= 1'b1;
      if (m_axis_tvalid && m_axis_tready) beat_count <= beat_count + 32'd1;
    end
  end

  // Two-stage data pipeline; both stages advance together whenever the output can move.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid          <= 1'b0;
      s1_last           <= 1'b0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      m_axis_tkeep      <= '0;
      m_axis_real_tdata <= '0;
      m_axis_imag_tdata <= '0;
      for (int i = 0; i < SAMPLES; i++) begin
        s1_re[i] <= '0;
        s1_im[i] <= '0;
      end
    end else if (pipe_en) begin
      s1_valid      <= accept;
      s1_last       <= beat_last;
      m_axis_tvalid <= s1_valid;
      m_axis_tlast  <= s1_valid && s1_last;
      m_axis_tkeep  <= {KW{s1_valid}};
      for (int i = 0; i < SAMPLES; i++) begin
        if (accept) begin
          s1_re[i] <= sum_re[i];
          s1_im[i] <= sum_im[i];
        end
        if (s1_valid) begin
          m_axis_real_tdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= scale(s1_re[i]);
          m_axis_imag_tdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= scale(s1_im[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_beam_combiner.sv
// Testbench for axis_beam_combiner. It drives three instances with the same
// inputs: the default (SHIFT=2, saturate), SHIFT=0 with saturate, and SHIFT=0
// with wrap. A beat-level model checks every output on every cycle; directed
// literals pin the model and the main scenarios.
module tb_axis_beam_combiner;
  localparam int NC  = 4;
  localparam int NS  = 8;
  localparam int SWD = 16;
  localparam int DW  = NS * SWD;

  logic              clock   = 1'b0;
  logic              reset   = 1'b0;
  logic [NC-1:0]     s_valid = '0;
  logic [NC-1:0]     s_last  = '0;
  logic [NC-1:0]     ch_mask = 4'hF;
  logic [NC*DW-1:0]  s_re    = '0;
  logic [NC*DW-1:0]  s_im    = '0;
  logic              m_ready = 1'b1;

  logic [NC-1:0]     rdy    [3];
  logic [DW-1:0]     o_re   [3];
  logic [DW-1:0]     o_im   [3];
  logic [DW/8-1:0]   o_keep [3];
  logic              o_last [3];
  logic              o_valid[3];
  logic              o_err  [3];
  logic [31:0]       o_cnt  [3];

  int checks = 0;
  int errors = 0;
  int cfg_sh  [3] = '{2, 0, 0};
  int cfg_sat [3] = '{1, 1, 0};

  for (genvar d = 0; d < 3; d++) begin : g_dut
    axis_beam_combiner #(
      .NUM_CH(NC), .SAMPLES(NS), .SAMPLE_WIDTH(SWD),
      .SHIFT(d == 0 ? 2 : 0), .SATURATE(d == 2 ? 0 : 1)
    ) u_dut (
      .clock(clock), .reset(reset),
      .s_axis_tvalid(s_valid), .s_axis_tready(rdy[d]),
      .s_axis_real_tdata(s_re), .s_axis_imag_tdata(s_im),
      .s_axis_tlast(s_last), .ch_mask(ch_mask),
      .m_axis_real_tdata(o_re[d]), .m_axis_imag_tdata(o_im[d]),
      .m_axis_tkeep(o_keep[d]), .m_axis_tlast(o_last[d]),
      .m_axis_tvalid(o_valid[d]), .m_axis_tready(m_ready),
      .tlast_err(o_err[d]), .beat_count(o_cnt[d])
    );
  end

  always #5 clock = ~clock;

  task automatic chk(input string name, input int d, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0d expected %0d", name, d, got, exp);
    end
  endtask

  // ---------------- behavioural model (beat level) ----------------
  logic [NC-1:0] mm;                 // active mask
  bit            m_init;
  bit            p1_v, p2_v, p1_l, p2_l;
  int            p1_re[NS], p1_im[NS], p2_re[NS], p2_im[NS];
  bit            m_err;
  int unsigned   m_cnt;

  function automatic int scale(input int s, input int sh, input int sat);
    int v;
    v = (s + ((1 << sh) >> 1)) >>> sh;
    if (sat != 0) begin
      if (v > 32767)       v = 32767;
      else if (v < -32768) v = -32768;
    end else begin
      v = v & 65535;
      if (v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic bit m_accept();
    return !m_init && (mm != '0) && ((s_valid & mm) == mm) && (!p2_v || m_ready);
  endfunction

  task automatic model_reset();
    mm = '0; m_init = 1'b1; p1_v = 1'b0; p2_v = 1'b0; p1_l = 1'b0; p2_l = 1'b0;
    m_err = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit acc, first, lst, anyl, alll;
    int sre[NS], sim[NS];
    acc = m_accept(); first = 1'b1; lst = 1'b0; anyl = 1'b0; alll = 1'b1;
    for (int c = 0; c < NC; c++) begin
      if (mm[c]) begin
        if (first) lst = s_last[c];
        first = 1'b0;
        anyl  = anyl | s_last[c];
        alll  = alll & s_last[c];
      end
    end
    for (int i = 0; i < NS; i++) begin
      sre[i] = 0; sim[i] = 0;
      for (int c = 0; c < NC; c++) begin
        if (mm[c]) begin
          sre[i] += int'($signed(s_re[(c*NS+i)*SWD +: SWD]));
          sim[i] += int'($signed(s_im[(c*NS+i)*SWD +: SWD]));
        end
      end
    end
    if (p2_v && m_ready) m_cnt++;
    if (!p2_v || m_ready) begin
      p2_v = p1_v; p2_l = p1_l; p2_re = p1_re; p2_im = p1_im;
      p1_v = acc;  p1_l = lst;  p1_re = sre;   p1_im = sim;
    end
    if (acc && anyl && !alll) m_err = 1'b1;
    if (m_init) begin
      mm = ch_mask; m_init = 1'b0;
    end else if (acc && lst) begin
      mm = ch_mask;
    end
  endtask

  // Compare process: check all three DUTs against the model at every negedge.
  initial begin
    logic [NC-1:0] er;
    bit acc;
    model_reset();
    forever begin
      @(negedge clock);
      if (reset) model_reset();
      acc = m_accept();
      for (int c = 0; c < NC; c++)
        er[c] = (reset || m_init) ? 1'b0 : (mm[c] ? acc : 1'b1);
      for (int d = 0; d < 3; d++) begin
        chk("s_tready",   d, int'(rdy[d]),    int'(er));
        chk("m_tvalid",   d, int'(o_valid[d]), int'(p2_v));
        chk("m_tkeep",    d, int'(o_keep[d]),  p2_v ? 65535 : 0);
        chk("m_tlast",    d, int'(o_last[d]),  int'(p2_v && p2_l));
        chk("tlast_err",  d, int'(o_err[d]),   int'(m_err));
        chk("beat_count", d, int'(o_cnt[d]),   int'(m_cnt));
        for (int i = 0; i < NS; i++) begin
          if (p2_v) begin
            chk("m_real", d, int'($signed(o_re[d][i*SWD +: SWD])), scale(p2_re[i], cfg_sh[d], cfg_sat[d]));
            chk("m_imag", d, int'($signed(o_im[d][i*SWD +: SWD])), scale(p2_im[i], cfg_sh[d], cfg_sat[d]));
          end else if (reset) begin
            chk("m_real_rst", d, int'(o_re[d][i*SWD +: SWD]), 0);
            chk("m_imag_rst", d, int'(o_im[d][i*SWD +: SWD]), 0);
          end
        end
      end
      @(posedge clock);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_ch(input int c, input int re, input int im);
    for (int i = 0; i < NS; i++) begin
      s_re[(c*NS+i)*SWD +: SWD] = 16'(re);
      s_im[(c*NS+i)*SWD +: SWD] = 16'(im);
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < NC*NS; k++) begin
      s_re[k*SWD +: SWD] = 16'($urandom);
      s_im[k*SWD +: SWD] = 16'($urandom);
    end
  endtask

  task automatic setup_beat(input int k, input int last_at, input int mode);
    fill_rand();
    s_last = (k == last_at) ? 4'hF : 4'h0;
    if (mode == 5) begin
      if (k == 3) ch_mask = 4'b0011;
      if (k == 7) s_last  = 4'b1000;
    end
  endtask

  // Send n beats as an AXI master, holding each beat until it is accepted.
  task automatic run_stream(input int n, input int st_lo, input int st_hi, input int last_at, input int mode);
    int sent, cyc;
    bit acc;
    sent = 0; cyc = 0;
    setup_beat(1, last_at, mode);
    s_valid = 4'hF;
    while (sent < n && cyc < 500) begin
      m_ready = !(cyc >= st_lo && cyc <= st_hi);
      @(negedge clock);
      acc = ((rdy[0] & s_valid) == s_valid);
      tick();
      cyc++;
      if (acc) begin
        sent++;
        if (sent < n) setup_beat(sent + 1, last_at, mode);
      end
    end
    s_valid = '0;
    m_ready = 1'b1;
    chk("stream_sent", 0, sent, n);
  endtask

  initial begin
    // model pinned with hand-computed values
    chk("model_sat_hi",   0, scale(80000, 0, 1), 32767);
    chk("model_sat_lo",   0, scale(-80000, 0, 1), -32768);
    chk("model_wrap_pos", 0, scale(80000, 0, 0), 14464);
    chk("model_wrap_neg", 0, scale(-80000, 0, 0), -14464);
    chk("model_shift",    0, scale(4000, 2, 1), 1000);
    chk("model_rnd_neg",  0, scale(-6, 2, 1), -1);
    chk("model_rnd_pos",  0, scale(6, 2, 1), 2);

    // reset state
    #1 reset = 1'b1;
    repeat (2) tick();
    chk("rst_tvalid", 0, int'(o_valid[0]), 0);
    chk("rst_tkeep",  0, int'(o_keep[0]), 0);
    chk("rst_count",  0, int'(o_cnt[0]), 0);
    chk("rst_tready", 0, int'(rdy[0]), 0);
    reset = 1'b0;
    tick();                                   // mask-load edge

    // one beat of 1000 / -1000 on all four channels
    for (int c = 0; c < NC; c++) fill_ch(c, 1000, -1000);
    s_last = 4'hF; s_valid = 4'hF;
    tick();                                   // accept edge
    s_valid = '0;
    tick();                                   // output stage loaded
    chk("lat_valid", 0, int'(o_valid[0]), 1);
    chk("lit_real",  0, int'($signed(o_re[0][0 +: SWD])), 1000);
    chk("lit_imag",  0, int'($signed(o_im[0][7*SWD +: SWD])), -1000);
    chk("lit_keep",  0, int'(o_keep[0]), 65535);
    chk("lit_sh0",   1, int'($signed(o_re[1][0 +: SWD])), 4000);
    tick();
    chk("lit_count1", 0, int'(o_cnt[0]), 1);

    // saturation and wrap with 20000 / -20000
    for (int c = 0; c < NC; c++) fill_ch(c, 20000, -20000);
    s_valid = 4'hF;
    tick();
    s_valid = '0;
    tick();
    chk("sat_real",  1, int'($signed(o_re[1][0 +: SWD])), 32767);
    chk("sat_imag",  1, int'($signed(o_im[1][0 +: SWD])), -32768);
    chk("wrap_real", 2, int'($signed(o_re[2][0 +: SWD])), 14464);
    chk("wrap_imag", 2, int'($signed(o_im[2][0 +: SWD])), -14464);
    chk("sh2_real",  0, int'($signed(o_re[0][0 +: SWD])), 20000);
    chk("sh2_imag",  0, int'($signed(o_im[0][0 +: SWD])), -20000);
    tick();
    chk("lit_count2", 0, int'(o_cnt[0]), 2);

    // 10-beat stream with a downstream stall in loop cycles 3..7
    run_stream(10, 3, 7, 10, 0);
    repeat (4) tick();
    chk("stall_count", 0, int'(o_cnt[0]), 12);

    // channel 2 valid arrives three cycles after the others
    fill_rand(); s_last = 4'hF; s_valid = 4'b1011;
    repeat (3) begin
      @(negedge clock);
      chk("late_rdy_low", 0, int'(rdy[0]), 0);
      tick();
    end
    s_valid = 4'hF;
    @(negedge clock);
    chk("late_rdy_join", 0, int'(rdy[0]), 15);
    tick();
    s_valid = '0;
    repeat (3) tick();
    chk("late_count", 0, int'(o_cnt[0]), 13);

    // mask 1111 -> 0011 requested at beat 3, packet ends at beat 8; ch3 tlast early at beat 7
    run_stream(8, -1, -1, 8, 5);
    fill_ch(0, 100, -100); fill_ch(1, 100, -100);
    fill_ch(2, 5000, 5000); fill_ch(3, 5000, 5000);
    s_last = 4'hF; s_valid = 4'hF;
    tick();
    s_valid = '0;
    tick();
    chk("mask_real",  0, int'($signed(o_re[0][0 +: SWD])), 50);
    chk("mask_imag",  0, int'($signed(o_im[0][0 +: SWD])), -50);
    chk("mask_sh0",   1, int'($signed(o_re[1][3*SWD +: SWD])), 200);
    repeat (3) tick();
    chk("tlast_err_set", 0, int'(o_err[0]), 1);
    chk("mask_count",    0, int'(o_cnt[0]), 22);

    // reset with two beats in flight
    ch_mask = 4'hF; fill_rand(); s_last = '0; s_valid = 4'hF; m_ready = 1'b1;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid", 0, int'(o_valid[0]), 0);
    chk("midrst_count", 0, int'(o_cnt[0]), 0);
    chk("midrst_err",   0, int'(o_err[0]), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    tick();                                   // mask-load edge
    tick();                                   // accept edge
    s_valid = '0;
    chk("postrst_empty", 0, int'(o_valid[0]), 0);
    tick();
    chk("postrst_valid", 0, int'(o_valid[0]), 1);
    repeat (3) tick();

    // randomized traffic, mask changes and backpressure; checked by the model
    repeat (400) begin
      s_valid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      s_last  = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF) : 4'h0;
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) ch_mask = 4'($urandom);
      fill_rand();
      tick();
    end
    s_valid = '0; m_ready = 1'b1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
